regfile_mp_sb: RTL and testbench
================================

Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the multi-issue integer pipeline.
- Generalises the current 4-read/2-write, 32x32 file to NUM_RD read ports and NUM_WR write ports, with configurable width and depth.
- Adds deterministic write-port priority, a per-register busy scoreboard (set at issue, cleared at writeback) and a sticky hazard-error flag.
- Sits between the decode/issue stage and the writeback stage.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of architectural registers; power of two, at least 4.
- NUM_RD, 4, number of read ports.
- NUM_WR, 2, number of write/issue ports.
- AW, $clog2(DEPTH), address width; derived, do not override.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- rd_addr  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW].
- rd_data  out  NUM_RD*DATA_W  read data; port i at [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  busy bit of the register addressed by port i.
- wr_en  in  NUM_WR  writeback enables.
- wr_addr  in  NUM_WR*AW  writeback addresses.
- wr_data  in  NUM_WR*DATA_W  writeback data.
- iss_en  in  NUM_WR  issue enables; mark the destination register busy.
- iss_addr  in  NUM_WR*AW  issue destination addresses.
- busy_vec  out  DEPTH  current scoreboard, bit r = register r busy.
- wr_collide  out  1  registered pulse: two enabled write ports hit the same nonzero address last cycle.
- hazard_err  out  1  sticky: issue to a register that was already busy.

Behaviour:
- Reset (async assert, sync release on clk):
  - All registers are 0; busy_vec = 0; wr_collide = 0; hazard_err = 0.
  - rd_data reads 0 during reset.
- Register 0:
  - Always reads 0 and is never busy.
  - Writes and issues to address 0 are ignored and never flag errors.
- Read path:
  - Combinational, zero latency.
  - rd_data[i] = stored value of rd_addr[i]; see the bypass feature for same-cycle writes.
  - rd_busy[i] = busy_vec[rd_addr[i]].
- Write: on posedge, each wr_en[j] with nonzero wr_addr[j] updates that register.
- Write collision:
  - When several enabled ports target the same address, the highest-index port wins.
  - This is the generalisation of the current rule that port 2 beats port 1.
  - wr_collide is 1 in the following cycle for exactly one cycle.
- Scoreboard, per nonzero register r, evaluated each posedge:
  - set = any iss_en[j] with iss_addr[j] == r.
  - clr = any wr_en[j] with wr_addr[j] == r.
  - set has priority: set&clr leaves busy = 1, because a new producer overrides the completing one.
  - clr alone gives busy = 0; neither leaves it unchanged.
- Hazard detection:
  - hazard_err is set at posedge if any iss_en[j] targets r where busy_vec[r]==1 and clr for r is 0.
  - hazard_err is also set if two issue ports target the same nonzero r in one cycle.
  - It holds until reset.
- Writeback to a non-busy register is legal (e.g. untracked writes): data is written, busy stays 0, no error.
- Reset mid-operation: asserting reset in any cycle discards pending issues and writes in that cycle; the all-zero state appears immediately.
- Out-of-range addresses cannot occur (DEPTH is a power of two).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - rd_data[i] forwards the winning same-cycle wr_data to matching nonzero rd_addr[i] (write-first), using the same highest-index priority.
  - rd_busy[i] reflects the post-update busy value (clr → 0, set → 1).
- Undefined:
  - rd_data and rd_busy show only the state stored before the edge.
  - The pipeline must insert a one-cycle writeback-to-read gap.

Test Plan:
- Reset check: assert reset mid-run after writing r5=0xDEADBEEF -> rd_data for r5 = 0 immediately; busy_vec = 0; hazard_err = 0.
- r0 protection: wr_en=2'b11, wr_addr={0,0}, data {0x1234,0x5678} -> reading r0 gives 0; wr_collide stays 0.
- Collision: port0 writes r7=0xAAAA0000, port1 writes r7=0x0000BBBB in the same cycle -> r7 = 0x0000BBBB; wr_collide = 1 for one cycle.
- Scoreboard: issue r3 -> busy_vec[3]=1 next cycle; writeback r3=0x11 two cycles later -> busy_vec[3]=0, r3 reads 0x11.
- Hazard cases:
  - Issue r9 while busy with no same-cycle writeback -> hazard_err = 1 and stays 1.
  - Issue r9 with a same-cycle writeback to r9 -> busy stays 1, hazard_err = 0.
  - Two issue ports both target r4 -> hazard_err = 1.
- Bypass:
  - With REGFILE_BYPASS_EN: write r12=0xCAFEF00D while rd_addr0=12 in the same cycle -> rd_data0 = 0xCAFEF00D before the edge.
  - Without the macro: rd_data0 shows the old value until after the edge.

Source files
------------

// File: rtl/regfile_mp_sb.sv
// Parametrised multi-port register file with issue/writeback busy scoreboard and sticky hazard flag.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data and post-update busy onto the read ports.
module regfile_mp_sb #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  parameter int NUM_RD = 4,
  parameter int NUM_WR = 2,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*AW-1:0]     rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_busy,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*AW-1:0]     wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0]        iss_en,
  input  logic [NUM_WR*AW-1:0]     iss_addr,
  output logic [DEPTH-1:0]         busy_vec,
  output logic                     wr_collide,
  output logic                     hazard_err
);

  logic [DATA_W-1:0] mem    [DEPTH];
  logic [DATA_W-1:0] wr_val [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_nx;
  logic [DEPTH-1:0]  set_v;
  logic [DEPTH-1:0]  clr_v;
  logic              dup_iss;
  logic              collide_nx;
  logic              haz_nx;

  // Per-register decode of writeback and issue ports. Ports are scanned in
  // ascending order so the highest-index enabled writer overwrites wr_val last.
  // Register 0 is excluded from every decode, so it is never written or busy.
  always_comb begin
    set_v      = '0;
    clr_v      = '0;
    dup_iss    = 1'b0;
    collide_nx = 1'b0;
    for (int unsigned r = 0; r < DEPTH; r++) wr_val[r] = '0;
    for (int unsigned j = 0; j < NUM_WR; j++) begin
      for (int unsigned r = 1; r < DEPTH; r++) begin
        if (wr_en[j] && (wr_addr[j*AW +: AW] == AW'(r))) begin
          if (clr_v[r]) collide_nx = 1'b1;
          clr_v[r]  = 1'b1;
          wr_val[r] = wr_data[j*DATA_W +: DATA_W];
        end
        if (iss_en[j] && (iss_addr[j*AW +: AW] == AW'(r))) begin
          if (set_v[r]) dup_iss = 1'b1;
          set_v[r] = 1'b1;
        end
      end
    end
  end

  // Issue beats a completing writeback: the new producer owns the register.
  assign busy_nx = (busy & ~clr_v) | set_v;
  assign haz_nx  = (|(set_v & busy & ~clr_v)) | dup_iss;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned r = 0; r < DEPTH; r++) mem[r] <= '0;
      busy       <= '0;
      wr_collide <= 1'b0;
      hazard_err <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < DEPTH; r++) begin
        if (clr_v[r]) mem[r] <= wr_val[r];
      end
      busy       <= busy_nx;
      wr_collide <= collide_nx;
      hazard_err <= hazard_err | haz_nx;
    end
  end

  assign busy_vec = busy;

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_RD; i++) begin
`ifdef REGFILE_BYPASS_EN
        rd_data[i*DATA_W +: DATA_W] = clr_v[rd_addr[i*AW +: AW]] ? wr_val[rd_addr[i*AW +: AW]]
                                                                : mem[rd_addr[i*AW +: AW]];
        rd_busy[i] = busy_nx[rd_addr[i*AW +: AW]];
`else
        rd_data[i*DATA_W +: DATA_W] = mem[rd_addr[i*AW +: AW]];
        rd_busy[i] = busy[rd_addr[i*AW +: AW]];
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed self-checking bench for regfile_mp_sb: expected values are queued as stimulus is driven
// and popped when the corresponding DUT output is sampled.
module tb_regfile_mp_sb;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 32;
  localparam int NUM_RD = 4;
  localparam int NUM_WR = 2;
  localparam int AW     = 5;

  logic                     clk;
  logic                     reset;
  logic [NUM_RD*AW-1:0]     rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data;
  logic [NUM_RD-1:0]        rd_busy;
  logic [NUM_WR-1:0]        wr_en;
  logic [NUM_WR*AW-1:0]     wr_addr;
  logic [NUM_WR*DATA_W-1:0] wr_data;
  logic [NUM_WR-1:0]        iss_en;
  logic [NUM_WR*AW-1:0]     iss_addr;
  logic [DEPTH-1:0]         busy_vec;
  logic                     wr_collide;
  logic                     hazard_err;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sbq[$];
  int   checks   = 0;
  int   failures = 0;

  regfile_mp_sb #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .NUM_RD(NUM_RD),
    .NUM_WR(NUM_WR)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_busy   (rd_busy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_en    (iss_en),
    .iss_addr  (iss_addr),
    .busy_vec  (busy_vec),
    .wr_collide(wr_collide),
    .hazard_err(hazard_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      failures++;
      $error("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
      return;
    end
    e = sbq.pop_front();
    assert (obs === e.val && tag == e.tag) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h (queued tag %s)", tag, obs, e.val, e.tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en    = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_en   = '0;
    iss_addr = '0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [31:0] d);
    wr_en[p]                  = 1'b1;
    wr_addr[p*AW +: AW]       = a;
    wr_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic iss(input int p, input logic [4:0] a);
    iss_en[p]            = 1'b1;
    iss_addr[p*AW +: AW] = a;
  endtask

  task automatic set_rd(input int p, input logic [4:0] a);
    rd_addr[p*AW +: AW] = a;
  endtask

  function automatic logic [31:0] rd(input int p);
    return rd_data[p*DATA_W +: DATA_W];
  endfunction

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    idle();

    // reset state
    set_rd(0, 5'd5);
    repeat (2) @(posedge clk);
    #1;
    push("rst_busy_vec", 32'h0);   chk("rst_busy_vec", busy_vec);
    push("rst_hazard", 32'h0);     chk("rst_hazard", {31'b0, hazard_err});
    push("rst_collide", 32'h0);    chk("rst_collide", {31'b0, wr_collide});
    push("rst_rd0", 32'h0);        chk("rst_rd0", rd(0));
    reset = 1'b0;
    tick();

    // plain write r5
    wr(0, 5'd5, 32'hDEADBEEF);
    push("wr_r5", 32'hDEADBEEF);
    tick();
    idle();
    #1 chk("wr_r5", rd(0));

    // r0 protection, dual write to address 0 is not a collision
    wr(0, 5'd0, 32'h1234);
    wr(1, 5'd0, 32'h5678);
    set_rd(1, 5'd0);
    push("r0_read", 32'h0);
    push("r0_collide", 32'h0);
    tick();
    idle();
    #1 chk("r0_read", rd(1));
    chk("r0_collide", {31'b0, wr_collide});

    // collision on r7, highest-index port wins
    wr(0, 5'd7, 32'hAAAA0000);
    wr(1, 5'd7, 32'h0000BBBB);
    set_rd(2, 5'd7);
    push("col_r7", 32'h0000BBBB);
    push("col_pulse", 32'h1);
    tick();
    idle();
    #1 chk("col_r7", rd(2));
    chk("col_pulse", {31'b0, wr_collide});
    push("col_pulse_end", 32'h0);
    tick();
    chk("col_pulse_end", {31'b0, wr_collide});

    // scoreboard: issue r3, writeback two cycles later
    iss(0, 5'd3);
    set_rd(2, 5'd3);
    push("sb_busy_set", 32'h0000_0008);
    push("sb_rd_busy", 32'h1);
    tick();
    idle();
    #1 chk("sb_busy_set", busy_vec);
    chk("sb_rd_busy", {31'b0, rd_busy[2]});
    tick();
    wr(1, 5'd3, 32'h11);
    push("sb_busy_clr", 32'h0);
    push("sb_r3", 32'h11);
    push("sb_no_haz", 32'h0);
    tick();
    idle();
    #1 chk("sb_busy_clr", busy_vec);
    chk("sb_r3", rd(2));
    chk("sb_no_haz", {31'b0, hazard_err});

    // untracked writeback to a non-busy register
    wr(0, 5'd10, 32'h55);
    set_rd(3, 5'd10);
    push("untracked_r10", 32'h55);
    push("untracked_busy", 32'h0);
    push("untracked_haz", 32'h0);
    tick();
    idle();
    #1 chk("untracked_r10", rd(3));
    chk("untracked_busy", busy_vec);
    chk("untracked_haz", {31'b0, hazard_err});

    // issue r9, then re-issue with same-cycle writeback: legal
    iss(0, 5'd9);
    tick();
    idle();
    iss(1, 5'd9);
    wr(0, 5'd9, 32'h99);
    set_rd(3, 5'd9);
    push("reiss_busy", 32'h0000_0200);
    push("reiss_haz", 32'h0);
    push("reiss_r9", 32'h99);
    tick();
    idle();
    #1 chk("reiss_busy", busy_vec);
    chk("reiss_haz", {31'b0, hazard_err});
    chk("reiss_r9", rd(3));

    // issue r9 while busy with no writeback: sticky hazard
    iss(0, 5'd9);
    push("haz_set", 32'h1);
    tick();
    idle();
    #1 chk("haz_set", {31'b0, hazard_err});
    push("haz_sticky", 32'h1);
    repeat (3) tick();
    chk("haz_sticky", {31'b0, hazard_err});

    // asynchronous reset mid-cycle with a pending write to r6
    set_rd(0, 5'd5);
    set_rd(1, 5'd6);
    wr(0, 5'd6, 32'h66666666);
    reset = 1'b1;
    push("mid_rst_r5", 32'h0);
    push("mid_rst_busy", 32'h0);
    push("mid_rst_haz", 32'h0);
    #1 chk("mid_rst_r5", rd(0));
    chk("mid_rst_busy", busy_vec);
    chk("mid_rst_haz", {31'b0, hazard_err});
    tick();
    idle();
    reset = 1'b0;
    push("mid_rst_r6", 32'h0);
    tick();
    chk("mid_rst_r6", rd(1));

    // issue to r0 is ignored
    iss(0, 5'd0);
    iss(1, 5'd0);
    push("iss_r0_busy", 32'h0);
    push("iss_r0_haz", 32'h0);
    tick();
    idle();
    #1 chk("iss_r0_busy", busy_vec);
    chk("iss_r0_haz", {31'b0, hazard_err});

    // two issue ports on r4
    iss(0, 5'd4);
    iss(1, 5'd4);
    push("dual_iss_haz", 32'h1);
    push("dual_iss_busy", 32'h0000_0010);
    tick();
    idle();
    #1 chk("dual_iss_haz", {31'b0, hazard_err});
    chk("dual_iss_busy", busy_vec);

    // same-cycle write/read of r12 and issue/read of r13
    set_rd(0, 5'd12);
    set_rd(1, 5'd13);
    wr(1, 5'd12, 32'hCAFEF00D);
    iss(0, 5'd13);
`ifdef REGFILE_BYPASS_EN
    push("byp_pre", 32'hCAFEF00D);
    push("byp_busy_pre", 32'h1);
`else
    push("byp_pre", 32'h0);
    push("byp_busy_pre", 32'h0);
`endif
    #1 chk("byp_pre", rd(0));
    chk("byp_busy_pre", {31'b0, rd_busy[1]});
    push("byp_post", 32'hCAFEF00D);
    push("byp_busy_post", 32'h1);
    tick();
    idle();
    #1 chk("byp_post", rd(0));
    chk("byp_busy_post", {31'b0, rd_busy[1]});

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
